// File: rtl/fdd_seek_ctrl_pkg.sv
// Shared types and constants for the floppy seek controller.
package fdd_seek_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIR_SETUP,
        ST_STEP_LOW,
        ST_STEP_HIGH,
        ST_SETTLE,
        ST_FINISH
    } state_t;

    localparam logic [6:0] MAX_TRACK = 7'd79;

    localparam int unsigned DEF_DIR_SETUP_CYC = 16;
    localparam int unsigned DEF_STEP_LOW_CYC  = 32;
    localparam int unsigned DEF_STEP_RATE_CYC = 48000;
    localparam int unsigned DEF_SETTLE_CYC    = 240000;
    localparam int unsigned DEF_MAX_RECAL     = 90;

    // Interval counter width: wide enough for the largest timing value, never below 18 bits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        w = $clog2(m + 1);
        return (w < 18) ? 18 : w;
    endfunction

endpackage

// File: rtl/fdd_seek_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous track-0 sense; resets to the inactive (high) level.
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    // Shift the raw input through two flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], i_d};
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/fdd_seek_ctrl.sv
// Floppy drive seek/recalibrate controller: generates dir/step timing and tracks head position.
module fdd_seek_ctrl
    import fdd_seek_ctrl_pkg::*;
#(
    parameter int unsigned DIR_SETUP_CYC = DEF_DIR_SETUP_CYC,
    parameter int unsigned STEP_LOW_CYC  = DEF_STEP_LOW_CYC,
    parameter int unsigned STEP_RATE_CYC = DEF_STEP_RATE_CYC,
    parameter int unsigned SETTLE_CYC    = DEF_SETTLE_CYC,
    parameter int unsigned MAX_RECAL     = DEF_MAX_RECAL
) (
    input  logic       xclk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_recal,
    input  logic [6:0] cmd_track,
    input  logic [1:0] cmd_drive,
    input  logic       trk0_n,
    output logic [3:0] sel_n,
    output logic       dir_n,
    output logic       step_n,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [6:0] cur_track
);

    localparam int unsigned CW = cnt_width(DIR_SETUP_CYC, STEP_LOW_CYC, STEP_RATE_CYC, SETTLE_CYC);
    localparam int unsigned SW = $clog2(MAX_RECAL + 1);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [SW-1:0]   r_steps, w_steps_nxt;
    logic [6:0]      r_cur, w_cur_nxt;
    logic [6:0]      r_target, w_target_nxt;
    logic            r_recal, w_recal_nxt;
    logic            r_dir_n, w_dir_nxt;
    logic [3:0]      r_sel_n, w_sel_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_error, w_err_nxt;
    logic            w_step_go;
    logic            w_trk0_n;

    sync2 u_sync2 (
        .i_clk (xclk),
        .i_rst (rst),
        .i_d   (trk0_n),
        .o_q   (w_trk0_n)
    );

    // State register.
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and datapath next values; step entry is shared by DIR_SETUP and STEP_HIGH.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_steps_nxt  = r_steps;
        w_cur_nxt    = r_cur;
        w_target_nxt = r_target;
        w_recal_nxt  = r_recal;
        w_dir_nxt    = r_dir_n;
        w_sel_nxt    = r_sel_n;
        w_busy_nxt   = r_busy;
        w_err_nxt    = r_error;
        w_step_go    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_recal_nxt  = cmd_recal;
                    w_target_nxt = cmd_track;
                    w_sel_nxt    = ~(4'b0001 << cmd_drive);
                    w_busy_nxt   = 1'b1;
                    w_err_nxt    = 1'b0;
                    w_steps_nxt  = '0;
                    if (cmd_recal) begin
                        w_dir_nxt   = 1'b1;
                        w_cnt_nxt   = CW'(DIR_SETUP_CYC - 1);
                        w_state_nxt = ST_DIR_SETUP;
                    end else if (cmd_track > MAX_TRACK) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_FINISH;
                    end else if (cmd_track == r_cur) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_dir_nxt   = (cmd_track < r_cur);
                        w_cnt_nxt   = CW'(DIR_SETUP_CYC - 1);
                        w_state_nxt = ST_DIR_SETUP;
                    end
                end
            end
            ST_DIR_SETUP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (r_recal && !w_trk0_n) begin
                    w_cur_nxt   = '0;
                    w_cnt_nxt   = CW'(SETTLE_CYC - 1);
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_step_go = 1'b1;
                end
            end
            ST_STEP_LOW: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
                    w_cnt_nxt   = CW'(STEP_RATE_CYC - STEP_LOW_CYC - 1);
                    w_state_nxt = ST_STEP_HIGH;
                end
            end
            ST_STEP_HIGH: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (r_recal) begin
                    if (!w_trk0_n) begin
                        w_cur_nxt   = '0;
                        w_cnt_nxt   = CW'(SETTLE_CYC - 1);
                        w_state_nxt = ST_SETTLE;
                    end else if (r_steps == SW'(MAX_RECAL)) begin
                        w_err_nxt   = 1'b1;
                        w_cur_nxt   = '0;
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_step_go = 1'b1;
                    end
                end else if (r_cur == r_target) begin
                    w_cnt_nxt   = CW'(SETTLE_CYC - 1);
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_step_go = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
                else             w_state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                w_sel_nxt   = 4'b1111;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Outward steps saturate at track 0 so an unknown start position during recal cannot wrap.
        if (w_step_go) begin
            w_state_nxt = ST_STEP_LOW;
            w_cnt_nxt   = CW'(STEP_LOW_CYC - 1);
            w_steps_nxt = r_steps + SW'(1);
            if (r_dir_n) w_cur_nxt = (r_cur == 7'd0) ? 7'd0 : r_cur - 7'd1;
            else         w_cur_nxt = r_cur + 7'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_steps  <= '0;
            r_cur    <= '0;
            r_target <= '0;
            r_recal  <= 1'b0;
            r_dir_n  <= 1'b1;
            r_sel_n  <= '1;
            r_busy   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_steps  <= w_steps_nxt;
            r_cur    <= w_cur_nxt;
            r_target <= w_target_nxt;
            r_recal  <= w_recal_nxt;
            r_dir_n  <= w_dir_nxt;
            r_sel_n  <= w_sel_nxt;
            r_busy   <= w_busy_nxt;
            r_error  <= w_err_nxt;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign step_n    = (r_state != ST_STEP_LOW);
    assign done      = (r_state == ST_FINISH);
    assign sel_n     = r_sel_n;
    assign dir_n     = r_dir_n;
    assign busy      = r_busy;
    assign error     = r_error;
    assign cur_track = r_cur;

endmodule

// File: tb/tb_fdd_seek_ctrl.sv
// Scoreboard bench for fdd_seek_ctrl with shortened timing parameters.
module tb_fdd_seek_ctrl;

    localparam int P_DIR    = 4;
    localparam int P_LOW    = 3;
    localparam int P_RATE   = 12;
    localparam int P_SETTLE = 20;
    localparam int P_RECAL  = 90;

    logic       xclk = 1'b0;
    logic       rst  = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_recal = 1'b0;
    logic [6:0] cmd_track = '0;
    logic [1:0] cmd_drive = '0;
    logic       trk0_n = 1'b1;
    logic       cmd_ready, dir_n, step_n, busy, done, error;
    logic [3:0] sel_n;
    logic [6:0] cur_track;

    typedef struct packed {
        logic [7:0] pulses;
        logic [6:0] trk;
        logic       err;
        logic       dir;
        logic [3:0] sel;
        logic       settle;
        logic [3:0] max_lat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   m_pulses = 0;
    int   m_fall = 0;
    logic m_prev_step = 1'b1;
    logic chk_rel = 1'b0;

    fdd_seek_ctrl #(
        .DIR_SETUP_CYC (P_DIR),
        .STEP_LOW_CYC  (P_LOW),
        .STEP_RATE_CYC (P_RATE),
        .SETTLE_CYC    (P_SETTLE),
        .MAX_RECAL     (P_RECAL)
    ) dut (
        .xclk      (xclk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_recal (cmd_recal),
        .cmd_track (cmd_track),
        .cmd_drive (cmd_drive),
        .trk0_n    (trk0_n),
        .sel_n     (sel_n),
        .dir_n     (dir_n),
        .step_n    (step_n),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cur_track (cur_track)
    );

    always #5 xclk = ~xclk;

    // Cycle counter.
    always @(posedge xclk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Monitor: step pulse timing, then pop and compare the expected result on done.
    always @(negedge xclk) begin
        exp_t e;
        if (rst) begin
            m_pulses    = 0;
            m_prev_step = 1'b1;
            chk_rel     = 1'b0;
        end else begin
            if (chk_rel) begin
                check("rel_sel", sel_n, 4'hF);
                check("rel_busy", busy, 0);
                check("rel_done", done, 0);
                chk_rel = 1'b0;
            end
            if (m_prev_step && !step_n) begin
                m_pulses++;
                if (q.size() > 0) begin
                    check("dir", dir_n, q[0].dir);
                    check("sel", sel_n, q[0].sel);
                end
                if (m_pulses == 1) check("dir_setup", (cyc - acc_cyc) >= P_DIR, 1);
                else               check("rate", cyc - m_fall, P_RATE);
                m_fall = cyc;
            end
            if (!m_prev_step && step_n) check("low_width", cyc - m_fall, P_LOW);
            m_prev_step = step_n;
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("pulses", m_pulses, e.pulses);
                    check("cur_track", cur_track, e.trk);
                    check("error", error, e.err);
                    check("done_busy", busy, 1);
                    if (e.max_lat != 0) check("latency", (cyc - acc_cyc) <= e.max_lat, 1);
                    if (m_pulses > 0)
                        check("settle", cyc - m_fall, P_RATE + (e.settle ? P_SETTLE : 0));
                end
                m_pulses = 0;
                chk_rel  = 1'b1;
            end
        end
    end

    task automatic do_cmd(input logic recal, input logic [6:0] trk, input logic [1:0] drv, input exp_t e);
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge xclk);
        check("ready", cmd_ready, 1);
        q.push_back(e);
        @(negedge xclk);
        cmd_valid = 1'b1;
        cmd_recal = recal;
        cmd_track = trk;
        cmd_drive = drv;
        @(posedge xclk);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        check("acc_busy", busy, 1);
        check("acc_sel", sel_n, e.sel);
        check("acc_ready", cmd_ready, 0);
        check("acc_err", error, (!recal && trk > 7'd79));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && q.size() > 0; i++) @(negedge xclk);
        check("done_seen", q.size(), 0);
        q.delete();
        @(negedge xclk);
        @(negedge xclk);
    endtask

    function automatic exp_t mk(input int p, input int t, input logic er, input logic d,
                                input logic [3:0] s, input logic st, input int lat);
        exp_t e;
        e.pulses  = 8'(p);
        e.trk     = 7'(t);
        e.err     = er;
        e.dir     = d;
        e.sel     = s;
        e.settle  = st;
        e.max_lat = 4'(lat);
        return e;
    endfunction

    initial begin
        repeat (3) @(negedge xclk);
        check("rst_sel", sel_n, 4'hF);
        check("rst_step", step_n, 1);
        check("rst_dir", dir_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", error, 0);
        check("rst_trk", cur_track, 0);
        rst = 1'b0;
        @(negedge xclk);
        check("rst_ready", cmd_ready, 1);

        do_cmd(1'b0, 7'd3, 2'd1, mk(3, 3, 0, 0, 4'b1101, 1, 0));
        wait_done();
        do_cmd(1'b0, 7'd5, 2'd2, mk(2, 5, 0, 0, 4'b1011, 1, 0));
        wait_done();
        do_cmd(1'b0, 7'd2, 2'd3, mk(3, 2, 0, 1, 4'b0111, 1, 0));
        wait_done();
        do_cmd(1'b0, 7'd2, 2'd0, mk(0, 2, 0, 0, 4'b1110, 1, 3));
        wait_done();
        do_cmd(1'b0, 7'd85, 2'd0, mk(0, 2, 1, 0, 4'b1110, 0, 3));
        wait_done();
        check("err_sticky", error, 1);
        do_cmd(1'b0, 7'd79, 2'd1, mk(77, 79, 0, 0, 4'b1101, 1, 0));
        wait_done();

        do_cmd(1'b1, 7'd0, 2'd2, mk(4, 0, 0, 1, 4'b1011, 1, 0));
        for (int i = 0; i < 2000 && m_pulses < 4; i++) @(negedge xclk);
        trk0_n = 1'b0;
        wait_done();
        trk0_n = 1'b1;

        do_cmd(1'b1, 7'd0, 2'd3, mk(90, 0, 1, 1, 4'b0111, 0, 0));
        wait_done();

        trk0_n = 1'b0;
        repeat (4) @(negedge xclk);
        do_cmd(1'b1, 7'd0, 2'd0, mk(0, 0, 0, 1, 4'b1110, 1, 0));
        wait_done();
        trk0_n = 1'b1;
        repeat (4) @(negedge xclk);

        do_cmd(1'b0, 7'd6, 2'd0, mk(6, 6, 0, 0, 4'b1110, 1, 0));
        repeat (10) @(negedge xclk);
        cmd_valid = 1'b1;
        cmd_track = 7'd50;
        cmd_drive = 2'd3;
        repeat (3) @(negedge xclk);
        cmd_valid = 1'b0;
        wait_done();

        @(negedge xclk);
        cmd_valid = 1'b1;
        cmd_recal = 1'b0;
        cmd_track = 7'd10;
        cmd_drive = 2'd2;
        @(posedge xclk);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        for (int i = 0; i < 200 && step_n; i++) @(negedge xclk);
        check("mid_low", step_n, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_step", step_n, 1);
        check("arst_sel", sel_n, 4'hF);
        check("arst_busy", busy, 0);
        check("arst_trk", cur_track, 0);
        check("arst_dir", dir_n, 1);
        repeat (2) @(negedge xclk);
        rst = 1'b0;
        @(negedge xclk);
        check("arst_ready", cmd_ready, 1);
        do_cmd(1'b0, 7'd1, 2'd1, mk(1, 1, 0, 0, 4'b1101, 1, 0));
        wait_done();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
